lcd_hd44780_driver: RTL and testbench
=====================================

Name: lcd_hd44780_driver

Overview:
- Character-LCD back end that sits directly downstream of the display test/pattern sequencer.
- Takes two 16-character ASCII lines plus a refresh strobe and drives an HD44780-compatible 16x2 module over an 8-bit, write-only bus.
- Performs the power-on initialisation, then rewrites both lines on each accepted refresh.
- Reports readiness to the upstream sequencer via `ready`.

Parameters:
- T_POWERON, 4_000_000: cycles to wait after reset before the first command (40 ms at 100 MHz).
- T_SETUP, 10: cycles RS/data are stable before E rises; the same count is used for hold after E falls.
- T_E, 50: cycles E is held high.
- T_CMD, 4_000: post-write wait for normal commands and characters (40 us).
- T_CLEAR, 164_000: post-write wait after 0x01 clear (1.64 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_btn  in  1  synchronous, active-low reset.
- line1  in  128  row 0 text; char 0 (leftmost) = [127:120], char 15 = [7:0].
- line2  in  128  row 1 text; same byte order as line1.
- refresh  in  1  single-cycle request to redraw both rows.
- ready  out  1  high = idle, no pending request, init complete.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0 (write-only).
- lcd_e  out  1  enable strobe.
- lcd_data  out  8  data bus.

Behaviour:
- Interface: one clock, `clk`. Reset `reset_btn` is synchronous and active-low. It is sampled only on the rising edge of `clk`.
- Reset values while `reset_btn` = 0: ready=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=0x00, pending=0, top FSM=PWR_WAIT, all counters=0.
- Reset mid-operation: a low `reset_btn` at any edge aborts immediately. After release the full power-on sequence restarts.
- Top FSM states: PWR_WAIT, INIT, IDLE, FRAME.
  - PWR_WAIT: counts T_POWERON cycles, then goes to INIT.
  - INIT: issues commands 0x38, 0x0C, 0x01, 0x06 in that order with RS=0, then goes to IDLE.
  - IDLE: ready=1. On refresh=1, or when pending=1, clears pending, copies the shadow lines into the frame buffer, drops ready, and goes to FRAME.
  - FRAME: 34 writes in order: command 0x80, line-1 chars 0..15 (RS=1), command 0xC0, line-2 chars 0..15 (RS=1). Then returns to IDLE.
- Write sub-FSM, one pass per byte: W_SETUP, W_PULSE, W_HOLD, W_WAIT.
  - W_SETUP: RS and data driven, E=0, for T_SETUP cycles.
  - W_PULSE: E=1 for T_E cycles.
  - W_HOLD: E=0, RS and data unchanged, for T_SETUP cycles.
  - W_WAIT: T_CLEAR cycles if the byte was command 0x01, otherwise T_CMD cycles.
  - One write therefore takes 2*T_SETUP + T_E + wait cycles.
  - lcd_data and lcd_rs change only on entry to W_SETUP.
- Refresh capture: any cycle with refresh=1 (outside reset) latches line1/line2 into the shadow registers.
  - If this happens outside IDLE (PWR_WAIT, INIT or FRAME), pending is set.
  - Multiple requests while busy collapse into one pending redraw using the last captured data.
  - A frame in progress uses its frame-buffer copy and is unaffected by input changes.
- refresh asserted on the same cycle that FRAME finishes: the request is captured and set pending. The FSM passes through IDLE for one cycle with ready=0, then starts the next frame.
- ready is registered. It rises on the first IDLE cycle with pending=0. It falls on the cycle after a refresh is accepted.
- All counters are sized to hold their parameter values. No counter wraps during normal operation.

Optional Feature:
- Macro: LCD_CLEAR_ON_REFRESH_EN.
- Defined: each FRAME begins with command 0x01 followed by a T_CLEAR wait, then the 34 writes (35 writes total).
- Undefined: no clear is issued; FRAME is exactly the 34 writes.

Test Plan:
All scenarios use T_POWERON=100, T_SETUP=2, T_E=4, T_CMD=20, T_CLEAR=50, and LCD_CLEAR_ON_REFRESH_EN undefined.
- Reset release, no refresh: lcd_data sequence 0x38, 0x0C, 0x01, 0x06, each with one E pulse of 4 cycles and RS=0. Gap after 0x01 is 50 cycles. ready rises 242 (+1 register) cycles after release.
- Single refresh, line1="0123456789ABCDEF", line2="Data Bit Test   ": E pulses carry 0x80, 0x30..0x39, 0x41..0x46, 0xC0, 0x44, 0x61, 0x74, ... 0x20. RS=1 only on characters. ready is low for 952 cycles.
- Refresh at mid-frame with a new pattern "ABCD...": the current frame completes with the old text. ready stays low. A second frame follows immediately with 0x41 first.
- Three refreshes during one frame with patterns P1, P2, P3: exactly one extra frame, and it carries P3.
- reset_btn low for 1 cycle mid-frame: lcd_e=0 and ready=0 on the next edge. The init sequence restarts; there are no further character writes until after 0x06.
- Timing check on every write: lcd_data and lcd_rs are stable from 2 cycles before E rises to 2 cycles after E falls. lcd_rw is 0 throughout.

Source files
------------

// File: rtl/lcd_hd44780_driver.sv
// HD44780 16x2 write-only driver: power-on init, then two-row redraw per refresh.
// Define LCD_CLEAR_ON_REFRESH_EN to prefix every frame with a 0x01 clear.
module lcd_hd44780_driver #(
   parameter int T_POWERON = 4_000_000,
   parameter int T_SETUP   = 10,
   parameter int T_E       = 50,
   parameter int T_CMD     = 4_000,
   parameter int T_CLEAR   = 164_000
) (
   input  logic         clk,
   input  logic         reset_btn,
   input  logic [127:0] line1,
   input  logic [127:0] line2,
   input  logic         refresh,
   output logic         ready,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_e,
   output logic [7:0]   lcd_data
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T_MAX = max2(max2(T_POWERON, T_CLEAR),
                               max2(max2(T_SETUP, T_E), T_CMD));
   localparam int CW    = $clog2(T_MAX + 1);

`ifdef LCD_CLEAR_ON_REFRESH_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif

   localparam logic [5:0] LAST_INIT  = 6'd3;
   localparam logic [5:0] LAST_FRAME = 6'(33 + OFF);

   typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, FRAME} top_t;
   typedef enum logic [1:0] {W_SETUP, W_PULSE, W_HOLD, W_WAIT} wst_t;

   top_t           state_q, state_d;
   wst_t           wst_q, wst_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [5:0]     idx_q, idx_d;
   logic           pend_q, pend_d;
   logic           ready_q, ready_d;
   logic           e_q, e_d;
   logic           rs_q;
   logic [7:0]     data_q;
   logic [127:0]   sh1_q, sh1_d, sh2_q, sh2_d;
   logic [127:0]   fb1_q, fb1_d, fb2_q, fb2_d;
   logic           load;
   logic [8:0]     byte_d;
   logic [CW-1:0]  wait_end;
   logic [5:0]     last_idx;

   // {rs, data} of write number idx within the current INIT or FRAME sequence.
   function automatic logic [8:0] byte_sel(
      input top_t         st,
      input logic [5:0]   idx,
      input logic [127:0] l1,
      input logic [127:0] l2
   );
      logic [5:0] j;
      logic [3:0] k;
      byte_sel = 9'h000;
      j = idx - 6'(OFF);
      k = 4'd0;
      if (st == INIT) begin
         unique case (idx[1:0])
            2'd0: byte_sel = {1'b0, 8'h38};
            2'd1: byte_sel = {1'b0, 8'h0C};
            2'd2: byte_sel = {1'b0, 8'h01};
            2'd3: byte_sel = {1'b0, 8'h06};
         endcase
      end else if (OFF == 1 && idx == 6'd0) begin
         byte_sel = {1'b0, 8'h01};
      end else if (j == 6'd0) begin
         byte_sel = {1'b0, 8'h80};
      end else if (j <= 6'd16) begin
         k = 4'(j - 6'd1);
         byte_sel = {1'b1, 8'(l1 >> {4'd15 - k, 3'b000})};
      end else if (j == 6'd17) begin
         byte_sel = {1'b0, 8'hC0};
      end else begin
         k = 4'(j - 6'd18);
         byte_sel = {1'b1, 8'(l2 >> {4'd15 - k, 3'b000})};
      end
   endfunction

   assign wait_end = (!rs_q && data_q == 8'h01) ? CW'(T_CLEAR - 1)
                                                : CW'(T_CMD - 1);
   assign last_idx = (state_q == INIT) ? LAST_INIT : LAST_FRAME;

   always_comb begin
      state_d = state_q;
      wst_d   = wst_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      pend_d  = pend_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      fb1_d   = fb1_q;
      fb2_d   = fb2_q;
      load    = 1'b0;

      if (refresh) begin
         sh1_d = line1;
         sh2_d = line2;
         if (state_q != IDLE) pend_d = 1'b1;
      end

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == CW'(T_POWERON - 1)) begin
               state_d = INIT;
               wst_d   = W_SETUP;
               cnt_d   = '0;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (refresh || pend_q) begin
               pend_d  = 1'b0;
               fb1_d   = sh1_d;
               fb2_d   = sh2_d;
               state_d = FRAME;
               wst_d   = W_SETUP;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         default: begin
            unique case (wst_q)
               W_SETUP: begin
                  if (cnt_q == CW'(T_SETUP - 1)) begin
                     wst_d = W_PULSE;
                     cnt_d = '0;
                  end
               end
               W_PULSE: begin
                  if (cnt_q == CW'(T_E - 1)) begin
                     wst_d = W_HOLD;
                     cnt_d = '0;
                  end
               end
               W_HOLD: begin
                  if (cnt_q == CW'(T_SETUP - 1)) begin
                     wst_d = W_WAIT;
                     cnt_d = '0;
                  end
               end
               W_WAIT: begin
                  if (cnt_q == wait_end) begin
                     cnt_d = '0;
                     if (idx_q == last_idx) begin
                        state_d = IDLE;
                     end else begin
                        idx_d = idx_q + 6'd1;
                        wst_d = W_SETUP;
                        load  = 1'b1;
                     end
                  end
               end
            endcase
         end
      endcase

      e_d     = (state_d == INIT || state_d == FRAME) && wst_d == W_PULSE;
      ready_d = (state_d == IDLE) && !pend_d;
      byte_d  = byte_sel(state_d, idx_d, fb1_d, fb2_d);
   end

   always_ff @(posedge clk) begin
      if (!reset_btn) begin
         state_q <= PWR_WAIT;
         wst_q   <= W_SETUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         ready_q <= 1'b0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         sh1_q   <= '0;
         sh2_q   <= '0;
         fb1_q   <= '0;
         fb2_q   <= '0;
      end else begin
         state_q <= state_d;
         wst_q   <= wst_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         ready_q <= ready_d;
         e_q     <= e_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         fb1_q   <= fb1_d;
         fb2_q   <= fb2_d;
         if (load) begin
            rs_q   <= byte_d[8];
            data_q <= byte_d[7:0];
         end
      end
   end

   assign ready    = ready_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_e    = e_q;
   assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Scoreboard bench for lcd_hd44780_driver with shortened timing parameters.
`timescale 1ns/1ps
module tb_lcd_hd44780_driver;

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         gap;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset_btn = 1'b0;
   logic         refresh = 1'b0;
   logic [127:0] line1 = '0;
   logic [127:0] line2 = '0;
   logic         ready, lcd_rs, lcd_rw, lcd_e;
   logic [7:0]   lcd_data;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   always #5 clk = ~clk;

   lcd_hd44780_driver #(
      .T_POWERON(100), .T_SETUP(2), .T_E(4), .T_CMD(20), .T_CLEAR(50)
   ) dut (
      .clk(clk), .reset_btn(reset_btn), .line1(line1), .line2(line2),
      .refresh(refresh), .ready(ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_e(lcd_e), .lcd_data(lcd_data)
   );

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic rs, input logic [7:0] d, input int gap);
      wr_t w;
      w.rs = rs;
      w.d = d;
      w.gap = gap;
      exp_q.push_back(w);
   endtask

   // gap = samples from previous E fall to this E rise (0 = not checked)
   task automatic push_init();
      push(1'b0, 8'h38, 0);
      push(1'b0, 8'h0C, 24);
      push(1'b0, 8'h01, 24);
      push(1'b0, 8'h06, 54);
   endtask

   task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] t;
      push(1'b0, 8'h80, 0);
      for (int k = 0; k < 16; k++) begin
         t = a << (8 * k);
         push(1'b1, t[127:120], 24);
      end
      push(1'b0, 8'hC0, 24);
      for (int k = 0; k < 16; k++) begin
         t = b << (8 * k);
         push(1'b1, t[127:120], 24);
      end
   endtask

   // monitor: pops one expected write per E rising edge, checks bus timing
   int   sidx = 0, last_chg = 0, last_fall = 0, hi_cnt = 0;
   bit   have_fall = 0;
   logic prev_e = 1'b0, prev_rs = 1'b0;
   logic [7:0] prev_d = 8'h00;
   wr_t  w;

   always @(posedge clk) begin
      #1;
      sidx++;
      if (!reset_btn) begin
         prev_e = 1'b0;
         have_fall = 0;
         hi_cnt = 0;
         prev_rs = lcd_rs;
         prev_d = lcd_data;
         last_chg = sidx;
      end else begin
         check(lcd_rw == 1'b0, "rw_low", 32'(lcd_rw), 0);
         if (lcd_rs != prev_rs || lcd_data != prev_d) begin
            check(!lcd_e && !prev_e && (!have_fall || sidx - last_fall >= 2),
                  "bus_hold", 32'(sidx - last_fall), 2);
            last_chg = sidx;
         end
         if (lcd_e && !prev_e) begin
            check(sidx - last_chg >= 2, "bus_setup", 32'(sidx - last_chg), 2);
            if (exp_q.size() == 0) begin
               check(0, "unexpected_write", {23'b0, lcd_rs, lcd_data}, 0);
            end else begin
               w = exp_q.pop_front();
               check(lcd_rs == w.rs && lcd_data == w.d, "write_byte",
                     {23'b0, lcd_rs, lcd_data}, {23'b0, w.rs, w.d});
               if (w.gap != 0 && have_fall)
                  check(sidx - last_fall == w.gap, "write_gap",
                        32'(sidx - last_fall), 32'(w.gap));
            end
            hi_cnt = 1;
         end else if (lcd_e) begin
            hi_cnt++;
         end
         if (!lcd_e && prev_e) begin
            check(hi_cnt == 4, "e_width", 32'(hi_cnt), 4);
            last_fall = sidx;
            have_fall = 1;
         end
         prev_e = lcd_e;
         prev_rs = lcd_rs;
         prev_d = lcd_data;
      end
   end

   task automatic pulse_refresh(input logic [127:0] a, input logic [127:0] b);
      line1 = a;
      line2 = b;
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic wait_ready(input int lim, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < lim);
   endtask

   task automatic busy_len(input int lim, output int n);
      n = 0;
      while (!ready && n < lim) begin
         n++;
         @(negedge clk);
      end
   endtask

   localparam logic [127:0] L1  = "0123456789ABCDEF";
   localparam logic [127:0] L2  = "Data Bit Test   ";
   localparam logic [127:0] LA  = "ABCDEFGHIJKLMNOP";
   localparam logic [127:0] LB  = "second row text ";
   localparam logic [127:0] P1a = "1111111111111111";
   localparam logic [127:0] P2a = "2222222222222222";
   localparam logic [127:0] P3a = "3333333333333333";
   localparam logic [127:0] P3b = "three wins here!";

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check(ready == 1'b0, "rst_ready", 32'(ready), 0);
      check(lcd_e == 1'b0, "rst_e", 32'(lcd_e), 0);
      check(lcd_rs == 1'b0, "rst_rs", 32'(lcd_rs), 0);
      check(lcd_rw == 1'b0, "rst_rw", 32'(lcd_rw), 0);
      check(lcd_data == 8'h00, "rst_data", 32'(lcd_data), 0);

      push_init();
      reset_btn = 1'b1;
      wait_ready(1000, n);
      check(n == 242 || n == 243, "init_ready_latency", 32'(n), 242);
      check(exp_q.size() == 0, "init_drain", 32'(exp_q.size()), 0);

      push_frame(L1, L2);
      pulse_refresh(L1, L2);
      busy_len(3000, n);
      check(n == 952, "frame_busy", 32'(n), 952);
      check(exp_q.size() == 0, "frame_drain", 32'(exp_q.size()), 0);

      push_frame(L1, L2);
      pulse_refresh(L1, L2);
      fork
         busy_len(5000, n);
         begin
            repeat (400) @(negedge clk);
            push_frame(LA, LB);
            pulse_refresh(LA, LB);
         end
      join
      check(n == 1905, "midframe_busy", 32'(n), 1905);
      check(exp_q.size() == 0, "midframe_drain", 32'(exp_q.size()), 0);

      push_frame(LA, L2);
      pulse_refresh(LA, L2);
      fork
         busy_len(5000, n);
         begin
            repeat (200) @(negedge clk);
            pulse_refresh(P1a, L1);
            repeat (200) @(negedge clk);
            pulse_refresh(P2a, L2);
            repeat (200) @(negedge clk);
            push_frame(P3a, P3b);
            pulse_refresh(P3a, P3b);
         end
      join
      check(n == 1905, "collapse_busy", 32'(n), 1905);
      check(exp_q.size() == 0, "collapse_drain", 32'(exp_q.size()), 0);

      push_frame(L1, L2);
      pulse_refresh(L1, L2);
      repeat (300) @(negedge clk);
      reset_btn = 1'b0;
      exp_q.delete();
      push_init();
      @(negedge clk);
      check(lcd_e == 1'b0, "abort_e", 32'(lcd_e), 0);
      check(ready == 1'b0, "abort_ready", 32'(ready), 0);
      reset_btn = 1'b1;
      wait_ready(1000, n);
      check(n == 242 || n == 243, "reinit_ready_latency", 32'(n), 242);
      check(exp_q.size() == 0, "reinit_drain", 32'(exp_q.size()), 0);

      push_frame(LA, LB);
      pulse_refresh(LA, LB);
      busy_len(3000, n);
      check(n == 952, "recover_busy", 32'(n), 952);
      repeat (5) @(negedge clk);
      check(exp_q.size() == 0, "final_drain", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
